dmux4_dispatch_ctrl: RTL and testbench
======================================

DMUX4_DISPATCH_CTRL -- requirements
Module: dmux4_dispatch_ctrl

Interface
REQ-001 Parameter: W, default 8, data width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_data  input  W  upstream word.
REQ-006 in_ready  output  1  block accepts word this cycle when high with in_valid.
REQ-007 mode  input  1  0 = round-robin dispatch; 1 = fixed dispatch.
REQ-008 fix_sel  input  2  destination index used when mode=1.
REQ-009 out_valid  output  4  one-hot; bit k high = held word offered to destination k.
REQ-010 out_data  output  W  held word, shared by all four destinations.
REQ-011 out_ready  input  4  per-destination accept.
REQ-012 s0  output  1  demux select LSB of current target.
REQ-013 s1  output  1  demux select MSB of current target.
REQ-014 xfer_cnt  output  8  count of completed output transfers.

Function
REQ-015 Two states, IDLE and HOLD, with a one-word holding register and a 2-bit target register tgt.
REQ-016 Acceptance occurs on a rising edge when in_valid and in_ready are both high.
REQ-017 in_ready is 1 in IDLE, and in HOLD equals out_ready[tgt], combinationally.
REQ-018 On acceptance, in_data is captured; tgt = fix_sel if mode=1, otherwise tgt = rr_ptr; state becomes HOLD.
REQ-019 mode and fix_sel are sampled only at acceptance; changes during HOLD do not alter tgt.
REQ-020 In HOLD: out_valid = one-hot(tgt) and out_data = the held word; in IDLE, out_valid = 4'b0000.
REQ-021 {s1,s0} equals tgt at all times, including IDLE, where it holds the last target.
REQ-022 Transfer completes on an edge in HOLD with out_ready[tgt]=1; out_ready bits other than tgt are ignored.
REQ-023 On transfer: xfer_cnt increments by 1, wrapping 255 -> 0.
REQ-024 On transfer with mode=0 at the acceptance of that word: rr_ptr = tgt+1 mod 4, so 3 -> 0.
REQ-025 Transfers under mode=1 leave rr_ptr unchanged.
REQ-026 Transfer with no simultaneous acceptance: state returns to IDLE.
REQ-027 Simultaneous transfer and acceptance: the new word is captured and state stays HOLD.
REQ-028 In the simultaneous case of REQ-027, a round-robin tgt uses the already-advanced pointer, giving 1 word/cycle throughput.
REQ-029 Latency: a word accepted at edge N is presented at out_valid/out_data from edge N onward, until its transfer edge.
REQ-030 HOLD with out_ready[tgt]=0 holds state, data, tgt and out_valid stable indefinitely; there is no timeout and no drop.

Reset
REQ-031 While rst_n=0, the block takes these values immediately, without waiting for a clock edge: state=IDLE, rr_ptr=0, tgt=0, held word=0, out_valid=0, out_data=0, s0=s1=0, xfer_cnt=0.
REQ-032 Reset asserted during HOLD discards the held word; no transfer is counted.
REQ-033 The first edge after rst_n rises behaves as IDLE.

Verification
REQ-034 Round-robin: mode=0, out_ready=4'b1111, stream in_data 0xA0..0xA5 back-to-back -> out_valid sequence 0001,0010,0100,1000,0001,0010; {s1,s0} = 0,1,2,3,0,1; xfer_cnt=6; in_ready held high throughout.
REQ-035 Fixed: mode=1, fix_sel=2, three words -> every transfer occurs on out_valid=0100 with s1=1, s0=0; rr_ptr remains 0, so a following mode=0 word goes to destination 0.
REQ-036 Backpressure: mode=0, word 0x5C accepted, out_ready=0 for 5 cycles -> out_valid, out_data=0x5C and s0/s1 stable and in_ready=0 throughout; raising only an out_ready bit other than tgt causes no transfer.
REQ-037 Mid-HOLD config change: accept a word with mode=1, fix_sel=3, then change fix_sel to 0 and mode to 0 before transfer -> word still delivered on out_valid=1000.
REQ-038 Reset mid-operation: assert rst_n=0 asynchronously while in HOLD with xfer_cnt=7 -> all outputs are at reset values before the next edge; after release, the next word goes to destination 0.
REQ-039 Counter wrap: 256 transfers -> xfer_cnt returns to 0 and rr_ptr is back at 0.

Source files
------------

// File: rtl/dmux4_dispatch_ctrl_if.sv
// dmux4_dispatch_ctrl_if: upstream/downstream handshake bundle for the four-way dispatcher
interface dmux4_dispatch_ctrl_if #(parameter int W = 8);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/dmux4_dispatch_ctrl.sv
// dmux4_dispatch_ctrl: one-word holding buffer dispatching to four destinations, round-robin or fixed
module dmux4_dispatch_ctrl #(parameter int W = 8) (
  input  logic                clk,
  input  logic                rst_n,
  dmux4_dispatch_ctrl_if.slave bus,
  input  logic                mode,
  input  logic [1:0]          fix_sel,
  output logic                s0,
  output logic                s1,
  output logic [7:0]          xfer_cnt
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t       state_q, state_d;
  logic [1:0]   tgt_q, tgt_d, rr_q, rr_d;
  logic [W-1:0] data_q, data_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         rr_word_q, rr_word_d;
  logic         xfer, acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      rr_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      rr_word_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      rr_q      <= rr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      rr_word_q <= rr_word_d;
    end
  end
  // rr_word_q remembers whether the held word was dispatched round-robin, so only those advance the pointer
  always_comb begin
    xfer         = (state_q == HOLD) && bus.out_ready[tgt_q];
    bus.in_ready = (state_q == IDLE) || bus.out_ready[tgt_q];
    acc          = bus.in_valid && bus.in_ready;
    rr_d         = (xfer && rr_word_q) ? rr_q + 2'd1 : rr_q;
    tgt_d        = acc ? (mode ? fix_sel : rr_d) : tgt_q;
    data_d       = acc ? bus.in_data : data_q;
    rr_word_d    = acc ? ~mode : rr_word_q;
    state_d      = acc ? HOLD : (xfer ? IDLE : state_q);
    cnt_d        = cnt_q + {7'd0, xfer};
    bus.out_valid = (state_q == HOLD) ? 4'b0001 << tgt_q : 4'b0000;
    bus.out_data  = (state_q == HOLD) ? data_q : '0;
    {s1, s0}      = tgt_q;
    xfer_cnt      = cnt_q;
  end
endmodule

// File: tb/tb_dmux4_dispatch_ctrl.sv
// tb_dmux4_dispatch_ctrl: directed and random stimulus checked against a transaction-level reference model
module tb_dmux4_dispatch_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] fix_sel = 2'd0;
  logic       s0, s1;
  logic [7:0] xfer_cnt;
  int compared = 0;
  int mismatched = 0;
  dmux4_dispatch_ctrl_if #(.W(8)) bus();
  dmux4_dispatch_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mode(mode), .fix_sel(fix_sel),
    .s0(s0), .s1(s1), .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  // reference: the word in the holding slot, where it is going, and the round-robin pointer
  bit       m_held;
  bit       m_is_rr;
  int       m_dest;
  int       m_word;
  int       m_rr;
  int       m_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_held = 0; m_is_rr = 0; m_dest = 0; m_word = 0; m_rr = 0; m_cnt = 0;
  endtask
  task automatic check_outputs();
    chk("out_valid", {28'd0, bus.out_valid}, m_held ? (32'd1 << m_dest) : 32'd0);
    chk("out_data", {24'd0, bus.out_data}, m_held ? m_word : 0);
    chk("in_ready", {31'd0, bus.in_ready}, (!m_held || bus.out_ready[m_dest]) ? 1 : 0);
    chk("sel", {30'd0, s1, s0}, m_dest);
    chk("xfer_cnt", {24'd0, xfer_cnt}, m_cnt);
  endtask
  task automatic model_edge();
    bit done, take;
    done = m_held && bus.out_ready[m_dest];
    take = bus.in_valid && (!m_held || bus.out_ready[m_dest]);
    if (done) begin
      m_cnt = (m_cnt + 1) % 256;
      if (m_is_rr) m_rr = (m_dest + 1) % 4;
      m_held = 0;
    end
    if (take) begin
      m_word  = bus.in_data;
      m_dest  = mode ? fix_sel : m_rr;
      m_is_rr = !mode;
      m_held  = 1;
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic [1:0] f, input logic [3:0] r);
    bus.in_valid = v; bus.in_data = d; mode = m; fix_sel = f; bus.out_ready = r;
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {28'd0, bus.out_valid}, 0);
    chk({tag, "_data"}, {24'd0, bus.out_data}, 0);
    chk({tag, "_sel"}, {30'd0, s1, s0}, 0);
    chk({tag, "_cnt"}, {24'd0, xfer_cnt}, 0);
  endtask
  task automatic async_reset();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    drive(0, 8'h00, 0, 2'd0, 4'b0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // round-robin streaming, one word per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'hA0 + 8'(i), 0, 2'd3, 4'b1111);
      cycle();
      chk("rr_valid", {28'd0, bus.out_valid}, 32'd1 << (i % 4));
      chk("rr_sel", {30'd0, s1, s0}, i % 4);
    end
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    chk("rr_total", {24'd0, xfer_cnt}, 6);
    // fixed dispatch to destination 2, then a round-robin word
    async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h30 + 8'(i), 1, 2'd2, 4'b1111);
      cycle();
      chk("fix_valid", {28'd0, bus.out_valid}, 32'b0100);
    end
    drive(1, 8'h77, 0, 2'd2, 4'b1111);
    cycle();
    chk("fix_then_rr", {28'd0, bus.out_valid}, 32'b0001);
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    // backpressure on a held word
    drive(1, 8'h5C, 0, 2'd0, 4'b0000);
    cycle();
    drive(0, 8'h00, 0, 2'd0, 4'b0000);
    repeat (5) cycle();
    chk("bp_data", {24'd0, bus.out_data}, 32'h5C);
    chk("bp_ready", {31'd0, bus.in_ready}, 0);
    drive(1, 8'h11, 0, 2'd0, ~(4'b0001 << m_dest));
    repeat (2) cycle();
    chk("bp_other_ready", {24'd0, bus.out_data}, 32'h5C);
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    cycle();
    // configuration change while holding
    drive(1, 8'h9E, 1, 2'd3, 4'b0000);
    cycle();
    drive(0, 8'h00, 0, 2'd0, 4'b0000);
    repeat (2) cycle();
    chk("cfg_hold", {28'd0, bus.out_valid}, 32'b1000);
    drive(0, 8'h00, 0, 2'd0, 4'b1000);
    cycle();
    cycle();
    // reset while holding with seven transfers counted
    async_reset();
    drive(1, 8'h40, 0, 2'd0, 4'b1111);
    repeat (7) cycle();
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    chk("cnt7", {24'd0, xfer_cnt}, 7);
    drive(1, 8'hEE, 0, 2'd0, 4'b0000);
    cycle();
    async_reset();
    drive(1, 8'h12, 1'b0, 2'd1, 4'b0000);
    cycle();
    chk("post_rst_dest", {28'd0, bus.out_valid}, 32'b0001);
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    // 256 transfers wrap the counter and the pointer
    async_reset();
    drive(1, 8'h00, 0, 2'd0, 4'b1111);
    for (int i = 0; i < 256; i++) begin
      bus.in_data = 8'(i);
      cycle();
    end
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    chk("wrap_cnt", {24'd0, xfer_cnt}, 0);
    drive(1, 8'h66, 0, 2'd0, 4'b0000);
    cycle();
    chk("wrap_dest", {28'd0, bus.out_valid}, 32'b0001);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 2'($urandom),
            4'($urandom));
      cycle();
    end
    drive(0, 8'h00, 0, 2'd0, 4'b1111);
    cycle();
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
